// File: rtl/i2c_seq_pkg.sv
// Shared state encoding, width helpers and default timing constants for the
// I2C read/write sequencer.
package i2c_seq_pkg;

  localparam int DEF_WAIT_CYCLES   = 250000;
  localparam int DEF_SHOW_INTERVAL = 25000000;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_WR_START = 3'd1;
  localparam state_t ST_WR_WAIT  = 3'd2;
  localparam state_t ST_WR_GAP   = 3'd3;
  localparam state_t ST_RD_START = 3'd4;
  localparam state_t ST_RD_WAIT  = 3'd5;
  localparam state_t ST_DRAIN    = 3'd6;

  function automatic int idx_width(input int num_bytes);
    return $clog2(num_bytes + 1);
  endfunction

  // Counter/pointer width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_rw_seq_fifo.sv
// Single-clock byte FIFO buffering read-burst data; dout is registered on pop.
module seq_fifo
  import i2c_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int PW = cnt_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]               count;
  logic                        do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_nxt(wr_ptr);
      if (do_pop) begin
        rd_ptr <= ptr_nxt(rd_ptr);
        dout   <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/i2c_rw_seq.sv
// EEPROM burst sequencer feeding the I2C byte controller: write burst with
// write-cycle gaps, read burst into a FIFO, then paced drain to the display.
// Optional readback checker enabled by I2C_RW_SEQ_VERIFY_EN (adds verify_err).
module i2c_rw_seq
  import i2c_seq_pkg::*;
#(
  parameter int          NUM_BYTES     = 10,
  parameter logic [15:0] BASE_ADDR     = 16'h0000,
  parameter logic [7:0]  DATA_INIT     = 8'h01,
  parameter logic        ADDR_2BYTE    = 1'b1,
  parameter int          WAIT_CYCLES   = DEF_WAIT_CYCLES,
  parameter int          SHOW_INTERVAL = DEF_SHOW_INTERVAL
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        i2c_clk,
  input  logic        write_req,
  input  logic        read_req,
  input  logic        i2c_end,
  input  logic [7:0]  rd_data,
  output logic        i2c_start,
  output logic        wr_en,
  output logic        rd_en,
  output logic [15:0] byte_addr,
  output logic [7:0]  wr_data,
  output logic        addr_num,
  output logic        busy,
  output logic [7:0]  dout,
  output logic        dout_valid
`ifdef I2C_RW_SEQ_VERIFY_EN
  ,
  output logic        verify_err
`endif
);

  localparam int IW = idx_width(NUM_BYTES);
  localparam int GW = cnt_width(WAIT_CYCLES);
  localparam int SW = cnt_width(SHOW_INTERVAL);

  state_t        state;
  logic [IW-1:0] idx;
  logic [GW-1:0] gap_cnt;
  logic [SW-1:0] show_cnt;
  logic          i2c_clk_d, i2c_end_d;
  logic          clk_rise, end_rise;
  logic          last_byte, gap_done, show_done;
  logic          push, pop, fifo_full, fifo_empty;

  assign clk_rise  = i2c_clk & ~i2c_clk_d;
  assign end_rise  = i2c_end & ~i2c_end_d;
  assign last_byte = (int'(idx) + 1) >= NUM_BYTES;
  assign gap_done  = (gap_cnt == GW'(WAIT_CYCLES - 1));
  assign show_done = (show_cnt == SW'(SHOW_INTERVAL - 1));

  // Start is decoded from state, so it drops the cycle after the first
  // i2c_clk rise seen in *_START: the controller samples it exactly once.
  assign i2c_start = (state == ST_WR_START) || (state == ST_RD_START);
  assign wr_en     = (state == ST_WR_START) || (state == ST_WR_WAIT) || (state == ST_WR_GAP);
  assign rd_en     = (state == ST_RD_START) || (state == ST_RD_WAIT);
  assign busy      = (state != ST_IDLE);
  assign byte_addr = BASE_ADDR + 16'(idx);
  assign wr_data   = DATA_INIT + 8'(idx);
  assign addr_num  = ADDR_2BYTE;

  // Full is impossible by construction; a stray push is simply dropped.
  assign push = (state == ST_RD_WAIT) && end_rise && !fifo_full;
  assign pop  = (state == ST_DRAIN) && show_done && !fifo_empty;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      gap_cnt    <= '0;
      show_cnt   <= '0;
      i2c_clk_d  <= 1'b0;
      i2c_end_d  <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      i2c_clk_d  <= i2c_clk;
      i2c_end_d  <= i2c_end;
      dout_valid <= pop;
      case (state)
        ST_IDLE: begin
          if (write_req) begin
            state <= ST_WR_START;
            idx   <= '0;
          end else if (read_req) begin
            state <= ST_RD_START;
            idx   <= '0;
          end
        end
        ST_WR_START: if (clk_rise) state <= ST_WR_WAIT;
        ST_WR_WAIT:  if (end_rise) state <= ST_WR_GAP;
        ST_WR_GAP: begin
          if (gap_done) begin
            gap_cnt <= '0;
            if (last_byte) state <= ST_IDLE;
            else begin
              idx   <= idx + IW'(1);
              state <= ST_WR_START;
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        ST_RD_START: if (clk_rise) state <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          if (end_rise) begin
            if (last_byte) state <= ST_DRAIN;
            else begin
              idx   <= idx + IW'(1);
              state <= ST_RD_START;
            end
          end
        end
        ST_DRAIN: begin
          show_cnt <= show_done ? '0 : show_cnt + SW'(1);
          // Leave one cycle after the pop that emptied the FIFO.
          if (dout_valid && fifo_empty) begin
            state    <= ST_IDLE;
            show_cnt <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  seq_fifo #(
    .WIDTH (8),
    .DEPTH (NUM_BYTES)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (push),
    .pop       (pop),
    .din       (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .dout      (dout)
  );

`ifdef I2C_RW_SEQ_VERIFY_EN
  logic [7:0] pop_cnt;
  logic       ovf;

  assign ovf = (state == ST_RD_WAIT) && end_rise && fifo_full;

  // Each drained byte k must equal DATA_INIT + k; errors stay until a new read.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      verify_err <= 1'b0;
      pop_cnt    <= '0;
    end else if (state == ST_IDLE && !write_req && read_req) begin
      verify_err <= 1'b0;
      pop_cnt    <= '0;
    end else begin
      if (dout_valid) begin
        pop_cnt <= pop_cnt + 8'd1;
        if (dout != DATA_INIT + pop_cnt) verify_err <= 1'b1;
      end
      if (ovf) verify_err <= 1'b1;
    end
  end
`endif

endmodule
